// File: rtl/seven_seg_pkg.sv
// Shared definitions for the four-digit seven-segment scanner: FSM encoding,
// active-low segment patterns and the all-anodes-off constant.
package seven_seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-side signal bundle: mux select out, BCD digit and masks in,
// active-low anode/segment/decimal-point drive out.
interface seven_seg_scan_if;
  logic       enable;
  logic [3:0] bcd_in;
  logic [3:0] blink_mask;
  logic [3:0] dp_mask;
  logic [1:0] digit_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    input  enable, bcd_in, blink_mask, dp_mask,
    output digit_sel, an, seg, dp
  );

  modport slave (
    output enable, bcd_in, blink_mask, dp_mask,
    input  digit_sel, an, seg, dp
  );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decode; non-decimal codes
// blank the digit.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd < 4'd10) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed display scanner: each slot blanks first so the mux
// settles and the previous digit cannot ghost, then shows the decoded digit.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  seven_seg_scan_if.master bus
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [1:0]      digit_sel_q, digit_sel_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [6:0]      dec_seg;
  logic            blink_off;

  bcd_to_seg u_dec (
    .bcd (bus.bcd_in),
    .seg (dec_seg)
  );

  // Blink phase is only consulted at the BLANK-to-SHOW edge, so a digit
  // never flickers partway through its slot.
  assign blink_off = blink_phase_q & bus.blink_mask[digit_sel_q];

  // NOTE: every next-state variable gets a default first so no path through
  // this block leaves one unassigned and infers a latch.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + 1'b1;
    digit_sel_d   = digit_sel_q;
    an_d          = an_q;
    seg_d         = seg_q;
    dp_d          = dp_q;
    blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ (blink_cnt_q == BLINK_LAST);

    if (!bus.enable) begin
      // Disable wins over any slot boundary; digit_sel deliberately holds.
      state_d = ST_BLANK;
      timer_d = '0;
      an_d    = AN_OFF;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (timer_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            timer_d = '0;
            an_d    = ~(4'b0001 << digit_sel_q);
            seg_d   = blink_off ? SEG_BLANK : dec_seg;
            dp_d    = blink_off | ~bus.dp_mask[digit_sel_q];
          end
        end
        ST_SHOW: begin
          if (timer_q == SHOW_LAST) begin
            state_d     = ST_BLANK;
            timer_d     = '0;
            digit_sel_d = digit_sel_q + 2'd1;
            an_d        = AN_OFF;
            seg_d       = SEG_BLANK;
            dp_d        = 1'b1;
          end
        end
        default: begin
          state_d = ST_BLANK;
          timer_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      timer_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      digit_sel_q   <= 2'd0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      digit_sel_q   <= digit_sel_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.digit_sel = digit_sel_q;
  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Multiplexed display driver for the four-digit seven-segment display.
- Sits on both sides of the digit-select mux.
  - Upstream: generates the 2-bit digit index that picks which BCD digit the mux presents.
  - Downstream: consumes the mux's 4-bit BCD output.
- Decodes that BCD digit to active-low segments and drives the active-low anodes.
- Inserts a blanking gap between digits to prevent ghosting; supports per-digit blink and decimal point.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (blank plus show); must exceed BLANK_CYCLES.
- BLANK_CYCLES, 500: cycles of the blank portion at the start of each slot; must be at least 1.
- BLINK_DIV, 25000000: cycles per blink half-period.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: display on when 1.
- bcd_in, input, 4: BCD digit from the mux for the current digit_sel.
- blink_mask, input, 4: bit i = 1 blinks digit i.
- dp_mask, input, 4: bit i = 1 lights the decimal point of digit i.
- digit_sel, output, 2: digit index driven to the mux select.
- an, output, 4: anodes, active low; an[i] enables digit i.
- seg, output, 7: {g,f,e,d,c,b,a}, active low.
- dp, output, 1: decimal point, active low.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset. All outputs are registered.
- Reset values:
  - digit_sel=0, an=4'b1111, seg=7'h7F, dp=1.
  - state=BLANK, slot timer=0, blink counter=0, blink_phase=0.
- FSM states: BLANK and SHOW. One slot timer counts up from 0.
- BLANK:
  - an=1111, seg=7F, dp=1; digit_sel is already stable so the mux output can settle.
  - When timer==BLANK_CYCLES-1: sample bcd_in, blink_mask[digit_sel], dp_mask[digit_sel].
  - Same cycle: load seg/dp from the decode, assert an[digit_sel]=0, timer<=0, go to SHOW.
- SHOW:
  - Outputs hold.
  - When timer==REFRESH_DIV-BLANK_CYCLES-1: digit_sel<=digit_sel+1 (3 wraps to 0), an<=1111, seg<=7F, dp<=1, timer<=0, go to BLANK.
- Timing:
  - Each digit slot is exactly REFRESH_DIV cycles.
  - After reset release, the first SHOW begins on clock edge number BLANK_CYCLES.
  - Latency from bcd_in sample to seg visible is 1 cycle; bcd_in changes during SHOW are ignored.
- Decode (active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - 10..15 decode to blank (7F).
- Blink:
  - Free-running counter; blink_phase toggles when the counter reaches BLINK_DIV-1, then the counter wraps to 0.
  - If blink_phase=1 and the sampled blink bit=1: seg=7F and dp=1 for that SHOW, but the anode is still driven.
  - blink_phase is sampled at the BLANK-to-SHOW transition only; no mid-slot flicker.
- dp output = ~sampled dp_mask bit (subject to blink).
- enable=0:
  - Next edge: state<=BLANK, timer<=0, an=1111, seg=7F, dp=1.
  - digit_sel holds; the blink counter keeps running.
  - When enable returns to 1, a full BLANK_CYCLES gap precedes the next SHOW of the same digit.
- Simultaneous events:
  - enable=0 beats a SHOW-end or BLANK-end on the same edge; digit_sel does not advance.
  - reset beats everything, at any point, mid-slot included: outputs go to reset values immediately.
- Width rules:
  - Slot timer width = $clog2(REFRESH_DIV).
  - Blink counter width = $clog2(BLINK_DIV).
  - digit_sel is 2 bits with natural wrap.

Decomposition:
- Shared package seven_seg_pkg:
  - State encoding for BLANK/SHOW.
  - Segment constants SEG_BLANK=7'h7F and SEG_DIGIT[0:9].
  - Anode constant AN_OFF=4'b1111.
- One sub-module, bcd_to_seg: purely combinational, 4-bit BCD to 7-bit active-low segments, using the package table. The scanner registers its output.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_DIV=64.
- Reset release, bcd_in tied to a model of the mux with digits {3,2,1,0} by index -> edge 2: an=1110, seg=40; edge 8: an=1111, digit_sel=1; edge 10: an=1101, seg=79. Slot period is 8 for all four digits; digit_sel wraps 3 to 0 at edge 32.
- bcd_in=12 for digit 2 -> during SHOW of digit 2: seg=7F, an=1011.
- blink_mask=0001, run past edge 64 -> digit 0 slots with phase=1: seg=7F, dp=1, an=1110. Phase=0 slots show normally; other digits are unaffected.
- dp_mask=0100, bcd_in=8 on digit 2 -> seg=00, dp=0, only during the digit-2 SHOW; dp=1 in BLANK.
- enable dropped mid-SHOW of digit 1 -> next edge: an=1111, seg=7F, digit_sel stays 1. After enable returns: 2 blank cycles, then digit 1 shows again.
- reset asserted mid-SHOW, asynchronous between edges -> outputs go to reset values without a clock edge; digit_sel=0.
